// File: rtl/math_pkg.sv
// Shared float helpers for the Math library: sign index, copysign merge and a
// width-legality check usable inside any module body.
`ifndef MATH_PKG_SV
`define MATH_PKG_SV

`define MATH_ASSERT_FP_WIDTH(W) \
    generate \
        if (!((W) == 16 || (W) == 32 || (W) == 64)) begin : g_bad_fp_width \
            $error("math: illegal float WIDTH %0d (legal: 16, 32, 64)", W); \
        end \
    endgenerate

package math_pkg;

    function automatic int unsigned fp_sign_idx(input int unsigned width);
        return width - 1;
    endfunction

    // Operands are zero-extended to 64 bits; the caller truncates back to its width.
    function automatic logic [63:0] fp_copysign(input logic [63:0] mag,
                                                input logic [63:0] sgn,
                                                input int unsigned width);
        logic [63:0] smask;
        smask = 64'd1 << fp_sign_idx(width);
        return (mag & ~smask) | (sgn & smask);
    endfunction

endpackage

`endif

// File: rtl/math_skid_buf.sv
// Two-entry elastic register: main drives the output, skid absorbs one result
// when the consumer stalls. in_ready depends on registered state only.
module math_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid, skid_valid;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             fire, pop;

    // Readies are held low while reset is asserted.
    assign in_ready  = rst_n & ~skid_valid;
    assign fire      = in_valid & in_ready;
    assign pop       = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (fire) begin
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (fire) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/math_copysignf_pipe.sv
// Registered copysign: joins magnitude and sign streams, merges the sign bit
// of b onto the magnitude of a, and buffers the result in an elastic stage.
module math_copysignf_pipe
    import math_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result_data
);

    `MATH_ASSERT_FP_WIDTH(WIDTH)

    logic             in_ready;
    logic             join_valid;
    logic [WIDTH-1:0] new_data;

    // Both operands are consumed together; a lone operand waits with ready low.
    assign join_valid = a_valid & b_valid;
    assign a_ready    = in_ready & b_valid;
    assign b_ready    = in_ready & a_valid;
    assign new_data   = WIDTH'(fp_copysign(64'(a_data), 64'(b_data), WIDTH));

    math_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (join_valid),
        .in_ready  (in_ready),
        .in_data   (new_data),
        .out_valid (result_valid),
        .out_ready (result_ready),
        .out_data  (result_data)
    );

endmodule

// File: tb/tb_math_copysignf_pipe.sv
// Directed bench for math_copysignf_pipe: join, latency, back-pressure,
// throughput, special values at 32 and 16 bits, and mid-operation reset.
module tb_math_copysignf_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, result_ready;
    logic        a_ready, b_ready, result_valid;
    logic [31:0] a_data, b_data, result_data;

    logic        h_a_valid, h_b_valid, h_result_ready;
    logic        h_a_ready, h_b_ready, h_result_valid;
    logic [15:0] h_a_data, h_b_data, h_result_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    math_copysignf_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data)
    );

    math_copysignf_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(h_a_valid), .a_ready(h_a_ready), .a_data(h_a_data),
        .b_valid(h_b_valid), .b_ready(h_b_ready), .b_data(h_b_data),
        .result_valid(h_result_valid), .result_ready(h_result_ready), .result_data(h_result_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pa(input int k);
        return 32'h3F80_0000 + 32'(k) * 32'h0001_2345 + (k[0] ? 32'h8000_0000 : 32'h0);
    endfunction

    function automatic logic [31:0] pb(input int k);
        return (k % 3 == 0) ? 32'h8000_0000 : 32'h0000_0001 + 32'(k);
    endfunction

    function automatic logic [31:0] pexp(input int k);
        logic [31:0] av, bv;
        av = pa(k);
        bv = pb(k);
        return {bv[31], av[30:0]};
    endfunction

    // Streams n pairs; result_ready is low for stall_len cycles from stall_from.
    task automatic stream(input int n, input int stall_from, input int stall_len,
                          input string tag, output int first_fire, output int last_out);
        int idx, oidx, cyc;
        idx = 0; oidx = 0; cyc = 0; first_fire = -1; last_out = -1;
        while (oidx < n && cyc < 4 * n + stall_len + 10) begin
            @(negedge clk);
            result_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            a_valid = (idx < n);
            b_valid = (idx < n);
            a_data  = pa(idx);
            b_data  = pb(idx);
            #1;
            chk({tag, "_rvalid"}, 64'(result_valid), 64'((idx - oidx) > 0));
            chk({tag, "_a_ready"}, 64'(a_ready), 64'((idx < n) && (idx - oidx) < 2));
            chk({tag, "_b_ready"}, 64'(b_ready), 64'((idx < n) && (idx - oidx) < 2));
            if (result_valid) chk({tag, "_data"}, 64'(result_data), 64'(pexp(oidx)));
            if (result_valid && result_ready) begin
                oidx++;
                last_out = cyc;
            end
            if (a_valid && a_ready && b_ready) begin
                if (first_fire < 0) first_fire = cyc;
                idx++;
            end
            cyc++;
        end
        chk({tag, "_all_out"}, 64'(oidx), 64'(n));
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; result_ready = 1'b1;
    endtask

    initial begin
        int ff, lo;
        rst_n = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; result_ready = 1'b1;
        a_data = 32'h1234_5678; b_data = 32'h8000_0000;
        h_a_valid = 1'b0; h_b_valid = 1'b0; h_result_ready = 1'b1;
        h_a_data = '0; h_b_data = '0;
        #2;
        chk("reset_rvalid", 64'(result_valid), 64'(0));
        chk("reset_rdata", 64'(result_data), 64'(0));
        chk("reset_a_ready", 64'(a_ready), 64'(0));
        chk("reset_b_ready", 64'(b_ready), 64'(0));
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Basic copysign and one-cycle latency
        @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1; a_data = 32'hBF80_0000; b_data = 32'h0000_0000;
        #1 chk("basic1_a_ready", 64'(a_ready), 64'(1));
        chk("basic1_pre_rvalid", 64'(result_valid), 64'(0));
        @(negedge clk);
        chk("basic1_rvalid", 64'(result_valid), 64'(1));
        chk("basic1_data", 64'(result_data), 64'h3F80_0000);
        a_data = 32'h4049_0FDB; b_data = 32'h8000_0000;
        @(negedge clk);
        chk("basic2_data", 64'(result_data), 64'hC049_0FDB);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("basic_drain", 64'(result_valid), 64'(0));

        // Join stall: lone a waits
        a_valid = 1'b1; a_data = 32'h4000_0000; b_data = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            #1 chk("join_a_ready", 64'(a_ready), 64'(0));
            chk("join_no_result", 64'(result_valid), 64'(0));
            @(negedge clk);
        end
        b_valid = 1'b1;
        #1 chk("join_a_ready_hi", 64'(a_ready), 64'(1));
        chk("join_b_ready_hi", 64'(b_ready), 64'(1));
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        chk("join_rvalid", 64'(result_valid), 64'(1));
        chk("join_data", 64'(result_data), 64'hC000_0000);
        @(negedge clk);
        chk("join_single", 64'(result_valid), 64'(0));

        // Back-pressure and throughput
        stream(8, 1, 6, "bp", ff, lo);
        stream(16, 0, 0, "tput", ff, lo);
        chk("tput_span", 64'(lo - ff), 64'(16));

        // Special values
        @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1; a_data = 32'h7FC1_2345; b_data = 32'h8000_0000;
        h_a_valid = 1'b1; h_b_valid = 1'b1; h_a_data = 16'h7C00; h_b_data = 16'h8001;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; h_a_valid = 1'b0; h_b_valid = 1'b0;
        chk("nan_data", 64'(result_data), 64'hFFC1_2345);
        chk("h_rvalid", 64'(h_result_valid), 64'(1));
        chk("h_inf_data", 64'(h_result_data), 64'hFC00);
        @(negedge clk);

        // Reset with main and skid both full
        result_ready = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 32'h3F00_0000; b_data = 32'h8000_0000;
        @(negedge clk);
        a_data = 32'h3E00_0000;
        @(negedge clk);
        #1 chk("full_rvalid", 64'(result_valid), 64'(1));
        chk("full_a_ready", 64'(a_ready), 64'(0));
        chk("full_data", 64'(result_data), 64'hBF00_0000);
        a_data = 32'hC120_0000; b_data = 32'h0000_0000;
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_rvalid", 64'(result_valid), 64'(0));
        chk("rst_mid_data", 64'(result_data), 64'(0));
        chk("rst_mid_a_ready", 64'(a_ready), 64'(0));
        chk("rst_mid_b_ready", 64'(b_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; result_ready = 1'b1;
        #1 chk("post_rst_a_ready", 64'(a_ready), 64'(1));
        chk("post_rst_rvalid", 64'(result_valid), 64'(0));
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        chk("post_rst_result", 64'(result_data), 64'h4120_0000);
        chk("post_rst_rvalid1", 64'(result_valid), 64'(1));
        @(negedge clk);
        chk("post_rst_no_stale", 64'(result_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
